pe_array_ctrl: RTL and testbench

//  Sequencer for a NUM_ROWS x NUM_COLS row-stationary PE array. Streams filter rows

---
 rtl/pe_array_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_ctrl.sv
// Sequencer for a row-stationary PE array: loads filters and ifmaps, staggers MAC starts, slides the window.
// Optional PE_CTRL_PERF_EN adds a saturating stall counter output (stall_cnt_o).
module pe_array_ctrl #(
  parameter int NUM_ROWS     = 3,
  parameter int NUM_COLS     = 3,
  parameter int FILTER_W     = 3,
  parameter int NUM_OUT_COLS = 8,
  parameter int STAGGER      = 5,
  localparam int NUM_DIAGS   = NUM_ROWS + NUM_COLS - 1,
  localparam int OC_W        = $clog2(NUM_OUT_COLS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 filter_valid_i,
  output logic                 filter_ready_o,
  input  logic                 ifmap_valid_i,
  output logic                 ifmap_ready_o,
  output logic [NUM_ROWS-1:0]  read_new_filter_val_o,
  output logic [NUM_DIAGS-1:0] read_new_ifmap_val_o,
  output logic [NUM_ROWS-1:0]  start_conv_o,
  input  logic                 psum_valid_i,
  output logic [OC_W-1:0]      out_col_o
`ifdef PE_CTRL_PERF_EN
 ,output logic [31:0]          stall_cnt_o
`endif
);

  localparam int EW    = (FILTER_W  > 1) ? $clog2(FILTER_W)  : 1;
  localparam int RW    = (NUM_ROWS  > 1) ? $clog2(NUM_ROWS)  : 1;
  localparam int DW    = (NUM_DIAGS > 1) ? $clog2(NUM_DIAGS) : 1;
  localparam int T_MAX = (NUM_ROWS - 1) * STAGGER;
  localparam int TW    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_FILT, S_LOAD_IFMAP, S_COMPUTE, S_WAIT, S_SLIDE, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   elem_q, elem_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   diag_q, diag_d;
  logic [TW-1:0]   t_q, t_d;
  logic [OC_W-1:0] out_col_q, out_col_d;
  logic            filt_xfer, ifm_xfer;

  assign filt_xfer = (state_q == S_LOAD_FILT) && filter_valid_i;
  assign ifm_xfer  = ((state_q == S_LOAD_IFMAP) || (state_q == S_SLIDE)) && ifmap_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      row_q     <= '0;
      diag_q    <= '0;
      t_q       <= '0;
      out_col_q <= '0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      row_q     <= row_d;
      diag_q    <= diag_d;
      t_q       <= t_d;
      out_col_q <= out_col_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    row_d     = row_q;
    diag_d    = diag_q;
    t_d       = t_q;
    out_col_d = out_col_q;
    case (state_q)
      S_IDLE: begin
        out_col_d = '0;
        if (start_i) begin
          state_d = S_LOAD_FILT;
          elem_d  = '0;
          row_d   = '0;
          diag_d  = '0;
          t_d     = '0;
        end
      end
      S_LOAD_FILT: begin
        if (filt_xfer) begin
          if (elem_q == EW'(FILTER_W - 1)) begin
            elem_d = '0;
            if (row_q == RW'(NUM_ROWS - 1)) begin
              row_d   = '0;
              state_d = S_LOAD_IFMAP;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            elem_d = elem_q + EW'(1);
          end
        end
      end
      S_LOAD_IFMAP: begin
        if (ifm_xfer) begin
          if (elem_q == EW'(FILTER_W - 1)) begin
            elem_d = '0;
            if (diag_q == DW'(NUM_DIAGS - 1)) begin
              diag_d  = '0;
              t_d     = '0;
              state_d = S_COMPUTE;
            end else begin
              diag_d = diag_q + DW'(1);
            end
          end else begin
            elem_d = elem_q + EW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (t_q == TW'(T_MAX)) begin
          t_d     = '0;
          state_d = S_WAIT;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_WAIT: begin
        if (psum_valid_i) begin
          out_col_d = out_col_q + OC_W'(1);
          state_d   = (out_col_d == OC_W'(NUM_OUT_COLS)) ? S_DONE : S_SLIDE;
        end
      end
      S_SLIDE: begin
        // One new ifmap element per diagonal shifts the window by one column.
        if (ifm_xfer) begin
          if (diag_q == DW'(NUM_DIAGS - 1)) begin
            diag_d  = '0;
            t_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            diag_d = diag_q + DW'(1);
          end
        end
      end
      S_DONE: begin
        out_col_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o                = (state_q != S_IDLE);
    done_o                = (state_q == S_DONE);
    filter_ready_o        = (state_q == S_LOAD_FILT);
    ifmap_ready_o         = (state_q == S_LOAD_IFMAP) || (state_q == S_SLIDE);
    read_new_filter_val_o = '0;
    read_new_ifmap_val_o  = '0;
    start_conv_o          = '0;
    if (filt_xfer) read_new_filter_val_o[row_q] = 1'b1;
    if (ifm_xfer)  read_new_ifmap_val_o[diag_q] = 1'b1;
    // Staggered starts let each row's psum arrive as the row below begins.
    if (state_q == S_COMPUTE) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        start_conv_o[r] = (t_q == TW'(r * STAGGER));
      end
    end
  end

  assign out_col_o = out_col_q;

`ifdef PE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_c;

  assign stall_c = (filter_ready_o && !filter_valid_i) || (ifmap_ready_o && !ifmap_valid_i);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start_i) begin
      stall_cnt_d = '0;
    end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized self-checking bench for pe_array_ctrl; event traces are compared against a job-level model.
module tb_pe_array_ctrl;
  localparam int NR = 3, NC = 3, FW = 3, NOC = 8, STG = 5;
  localparam int ND = NR + NC - 1;
  localparam int OCW = $clog2(NOC + 1);

  logic clk = 1'b0;
  logic rst_i, start_i, fv, iv, pv;
  logic busy, done, fr, ir;
  logic [NR-1:0] fe, sc;
  logic [ND-1:0] ie;
  logic [OCW-1:0] oc;
  logic start1, fv1, iv1, pv1, busy1, done1, fr1, ir1;
  logic [NR-1:0] fe1, sc1;
  logic [ND-1:0] ie1;
  logic [0:0] oc1;
`ifdef PE_CTRL_PERF_EN
  logic [31:0] stall, stall1;
`endif

  always #5 clk = ~clk;

  pe_array_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .FILTER_W(FW), .NUM_OUT_COLS(NOC), .STAGGER(STG)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy), .done_o(done),
    .filter_valid_i(fv), .filter_ready_o(fr), .ifmap_valid_i(iv), .ifmap_ready_o(ir),
    .read_new_filter_val_o(fe), .read_new_ifmap_val_o(ie), .start_conv_o(sc),
    .psum_valid_i(pv), .out_col_o(oc)
`ifdef PE_CTRL_PERF_EN
   ,.stall_cnt_o(stall)
`endif
  );

  pe_array_ctrl #(.NUM_ROWS(NR), .NUM_COLS(NC), .FILTER_W(FW), .NUM_OUT_COLS(1), .STAGGER(STG)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .filter_valid_i(fv1), .filter_ready_o(fr1), .ifmap_valid_i(iv1), .ifmap_ready_o(ir1),
    .read_new_filter_val_o(fe1), .read_new_ifmap_val_o(ie1), .start_conv_o(sc1),
    .psum_valid_i(pv1), .out_col_o(oc1)
`ifdef PE_CTRL_PERF_EN
   ,.stall_cnt_o(stall1)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, viol = 0;
  int frows[$], idiags[$], icyc[$], crow[$], ccyc[$], pcyc[$], poc[$], dcyc[$];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Trace recorder for the main instance
  always @(negedge clk) begin
    cyc++;
    if (!rst_i) begin
      if (!$onehot0(fe) || !$onehot0(ie) || !$onehot0(sc) || (fr && ir)) viol++;
      if (fe != '0) begin
        frows.push_back(onehot_idx(32'(fe)));
        if (!fv || !fr) viol++;
      end
      if (ie != '0) begin
        idiags.push_back(onehot_idx(32'(ie)));
        icyc.push_back(cyc);
        if (!iv || !ir) viol++;
      end
      for (int r = 0; r < NR; r++) if (sc[r]) begin crow.push_back(r); ccyc.push_back(cyc); end
      if (pv) begin pcyc.push_back(cyc); poc.push_back(int'(oc)); end
      if (done) dcyc.push_back(cyc);
    end
  end

  task automatic clear_trace();
    frows.delete(); idiags.delete(); icyc.delete(); crow.delete(); ccyc.delete();
    pcyc.delete(); poc.delete(); dcyc.delete(); viol = 0;
  endtask

  // mode 0: random, 1: filter valid toggling, 2: all valids high, 3: 7-cycle ifmap gap
  task automatic run_job(input int mode);
    int gap = 0;
    clear_trace();
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int k = 0; k < 3000 && dcyc.size() == 0; k++) begin
      case (mode)
        0: begin
          fv = ($urandom % 2) == 0; iv = ($urandom % 4) != 0;
          pv = ($urandom % 4) == 0; start_i = ($urandom % 8) == 0;
        end
        1: begin fv = k[0]; iv = 1'b1; pv = ($urandom % 3) == 0; end
        2: begin fv = 1'b1; iv = 1'b1; pv = 1'b1; end
        default: begin
          fv = 1'b1; pv = 1'b1;
          if (frows.size() >= NR * FW && gap < 7) begin iv = 1'b0; gap++; end
          else iv = 1'b1;
        end
      endcase
      @(posedge clk); #1;
    end
    start_i = 1'b0; fv = 1'b0; iv = 1'b0; pv = 1'b0;
    #3;
    check_val("idle_busy", busy, 0);
    check_val("idle_out_col", oc, 0);
  endtask

  // Expected trace derived from the job rules: load order, pass timing, accept timing
  task automatic check_job();
    int n_load = ND * FW;
    int n_ifm  = n_load + (NOC - 1) * ND;
    int j = 0, acc = 0, wstart = 0, start = 0;
    check_val("done_once", dcyc.size(), 1);
    check_val("invariants", viol, 0);
    check_val("filt_cnt", frows.size(), NR * FW);
    for (int k = 0; k < frows.size() && k < NR * FW; k++) check_val("filt_row", frows[k], k / FW);
    check_val("ifmap_cnt", idiags.size(), n_ifm);
    for (int k = 0; k < idiags.size() && k < n_ifm; k++)
      check_val("ifmap_diag", idiags[k], (k < n_load) ? (k / FW) : ((k - n_load) % ND));
    check_val("conv_cnt", crow.size(), NOC * NR);
    if (idiags.size() == n_ifm && crow.size() == NOC * NR && dcyc.size() == 1) begin
      for (int p = 0; p < NOC; p++) begin
        start = icyc[n_load - 1 + p * ND] + 1;
        for (int r = 0; r < NR; r++) begin
          check_val("conv_row", crow[p * NR + r], r);
          check_val("conv_time", ccyc[p * NR + r], start + r * STG);
        end
        wstart = ccyc[p * NR + NR - 1] + 1;
        while (j < pcyc.size() && pcyc[j] < wstart) j++;
        check_val("accept_found", j < pcyc.size(), 1);
        if (j < pcyc.size()) begin
          acc = pcyc[j];
          check_val("out_col_at_accept", poc[j], p);
          if (p < NOC - 1) check_val("slide_after_accept", icyc[n_load + p * ND] > acc, 1);
          else             check_val("done_time", dcyc[0], acc + 1);
          j++;
        end
      end
    end
  endtask

  initial begin
    int k_c = -1, k_acc = -1, k_done = -1, n_ie1 = 0, n_fe1 = 0, v1 = 0;
    rst_i = 1'b1; start_i = 1'b0; fv = 1'b0; iv = 1'b0; pv = 1'b0;
    start1 = 1'b0; fv1 = 1'b0; iv1 = 1'b0; pv1 = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_i = 1'b0;
    #3;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_filter_ready", fr, 0);
    check_val("rst_ifmap_ready", ir, 0);
    check_val("rst_out_col", oc, 0);
    check_val("rst_start_conv", sc, 0);

    run_job(2); check_job();
    run_job(1); check_job();
    for (int n = 0; n < 3; n++) begin run_job(0); check_job(); end

    // Abort in WAIT with out_col=4, then a full job must still run
    clear_trace();
    @(posedge clk); #1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0; fv = 1'b1; iv = 1'b1; pv = 1'b1;
    for (int k = 0; k < 2000 && crow.size() < 5 * NR; k++) begin
      if (oc == OCW'(4)) pv = 1'b0;
      @(posedge clk); #1;
    end
    pv = 1'b0;
    check_val("rst_reach_wait", crow.size() >= 5 * NR, 1);
    check_val("pre_rst_out_col", oc, 4);
    check_val("pre_rst_busy", busy, 1);
    rst_i = 1'b1;
    @(posedge clk); #1; rst_i = 1'b0; #3;
    check_val("abort_busy", busy, 0);
    check_val("abort_out_col", oc, 0);
    check_val("abort_ready", {fr, ir}, 0);
    check_val("abort_enables", {fe, ie, sc}, 0);
    repeat (5) @(posedge clk);
    check_val("abort_no_done", dcyc.size(), 0);
    fv = 1'b0; iv = 1'b0;
    run_job(0); check_job();

    // Single output column: no slide, done right after the only psum
    @(posedge clk); #1; start1 = 1'b1; fv1 = 1'b1; iv1 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      pv1 = (k_c >= 0) && (k == k_c + 3);
      if (pv1) k_acc = k;
      #3;
      if (ie1 != '0) n_ie1++;
      if (fe1 != '0) n_fe1++;
      if (fr1 && ir1) v1++;
      if (sc1[NR-1] && k_c < 0) k_c = k;
      if (done1) begin
        k_done = k;
        check_val("one_col_out_col", oc1, 1);
        break;
      end
    end
    fv1 = 1'b0; iv1 = 1'b0; pv1 = 1'b0;
    check_val("one_col_done_time", k_done, k_acc + 1);
    check_val("one_col_ifmap_xfers", n_ie1, ND * FW);
    check_val("one_col_filter_xfers", n_fe1, NR * FW);
    check_val("one_col_ready_excl", v1, 0);
    @(posedge clk); #4;
    check_val("one_col_idle", busy1, 0);
`ifdef PE_CTRL_PERF_EN
    check_val("one_col_stall", stall1, 0);
    run_job(3); check_job();
    check_val("stall_cnt", stall, 7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
